// File: rtl/fifo_wr_arbiter.sv
// +----------------------------------------------------------------------------+
// | fifo_wr_arbiter                                                            |
// | Round-robin, packet-atomic, burst-capped sharing of the fifo_asyn write    |
// | port among NUM_REQ write-domain requesters.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                          w_clk,
  input  logic                          w_rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [GW-1:0]         r_grant_id;
  logic [GW-1:0]         w_grant_nxt;
  logic [GW-1:0]         r_last_grant;
  logic [GW-1:0]         w_last_grant_nxt;
  logic [CW-1:0]         r_burst_cnt;
  logic [CW-1:0]         w_burst_nxt;
  logic [GW-1:0]         w_cand;
  logic [GW-1:0]         w_pick;
  logic                  w_found;
  logic                  w_xfer;
  logic                  w_end;
  logic [NUM_REQ-1:0]    w_one;
  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign w_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First requesting index after the previous owner, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = GW'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_burst_nxt      = r_burst_cnt;
    w_one            = NUM_REQ'(1);
    w_xfer           = (r_state == BUSY) && req[r_grant_id] && !full;
    w_end            = w_xfer && (last[r_grant_id] ||
                                  (r_burst_cnt == CW'(MAX_BURST - 1)));
    ack              = '0;
    w_en             = 1'b0;
    w_data           = '0;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_burst_nxt = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_xfer) begin
          ack    = w_one << r_grant_id;
          w_en   = 1'b1;
          w_data = w_slice[r_grant_id];
          // Packet end and burst cap landing together close one grant only.
          if (w_end) begin
            w_last_grant_nxt = r_grant_id;
            w_burst_nxt      = '0;
            w_state_nxt      = IDLE;
          end else begin
            w_burst_nxt = r_burst_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == BUSY);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_wr_arbiter                                                         |
// | Randomised requesters with a per-requester expected-word scoreboard and    |
// | a round-robin / burst-cap reference model; directed reset scenarios.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 8;
  localparam int GW = 2;

  logic             w_clk    = 1'b0;
  logic             w_rstn   = 1'b0;
  logic [NR-1:0]    req      = '0;
  logic [NR-1:0]    last     = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             full     = 1'b0;
  logic [NR-1:0]    ack;
  logic             w_en;
  logic [DW-1:0]    w_data;
  logic [GW-1:0]    grant_id;
  logic             busy;

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  // Word = {last, data}. drv_q feeds the requester pins; exp_q is what the
  // FIFO must eventually see from that requester, in order.
  logic [8:0] drv_q [NR][$];
  logic [8:0] exp_q [NR][$];

  logic [NR-1:0] took     = '0;
  logic [NR-1:0] req_prev = '0;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .w_clk    (w_clk),
    .w_rstn   (w_rstn),
    .req      (req),
    .last     (last),
    .req_data (req_data),
    .ack      (ack),
    .full     (full),
    .w_en     (w_en),
    .w_data   (w_data),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next owner: first set bit strictly after the previous owner, cyclically.
  function automatic logic [GW-1:0] rr_pick(input logic [NR-1:0] r, input int prev);
    logic [GW-1:0] ix;
    for (int k = 1; k <= NR; k++) begin
      ix = GW'((prev + k) % NR);
      if (r[ix]) return ix;
    end
    return '0;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += drv_q[i].size();
    return s;
  endfunction

  function automatic int leftover();
    int s = 0;
    for (int i = 0; i < NR; i++) s += exp_q[i].size();
    return s;
  endfunction

  task automatic drive_cycle(input bit gen);
    logic [8:0] h;
    int         len;
    @(negedge w_clk);
    for (int i = 0; i < NR; i++)
      if (took[i] && drv_q[i].size() > 0) h = drv_q[i].pop_front();
    for (int i = 0; i < NR; i++) begin
      if (gen && drv_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, 12);
        for (int w = 0; w < len; w++) begin
          h = {(w == len - 1), 8'($urandom)};
          drv_q[i].push_back(h);
          exp_q[i].push_back(h);
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (drv_q[i].size() == 0)          req[i] = 1'b0;
      else if (req_prev[i] && !took[i])  req[i] = 1'b1;
      else                               req[i] = ($urandom_range(0, 4) != 0);
      h = (drv_q[i].size() > 0) ? drv_q[i][0] : 9'h0;
      last[i] = h[8];
      req_data[i*DW +: DW] = h[7:0];
    end
    req_prev = req;
    full     = ($urandom_range(0, 4) == 0);
    #2;
    took = ack;
  endtask

  // Monitor / scoreboard
  initial begin
    logic          prev_busy;
    logic          expect_idle;
    logic          exp_x;
    logic [NR-1:0] prev_req;
    logic [NR-1:0] one;
    logic [NR-1:0] exp_ack;
    logic [GW-1:0] prev_gid;
    logic [GW-1:0] exp_gid;
    logic [8:0]    e;
    int            m_last;
    int            words;
    prev_busy = 1'b0; expect_idle = 1'b0; prev_req = '0; prev_gid = '0;
    m_last = NR - 1; words = 0; one = NR'(1);
    forever begin
      @(negedge w_clk);
      #3;
      if (!mon_en) begin
        prev_busy = 1'b0; expect_idle = 1'b0; prev_req = '0; prev_gid = '0;
        m_last = NR - 1; words = 0;
      end else begin
        if (prev_busy) begin
          check("grant_hold", 32'(busy), 32'(!expect_idle));
          if (busy) check("grant_stable", 32'(grant_id), 32'(prev_gid));
        end else begin
          check("arb_latency", 32'(busy), 32'(prev_req != '0));
          if (busy && prev_req != '0) begin
            exp_gid = rr_pick(prev_req, m_last);
            check("rr_grant", 32'(grant_id), 32'(exp_gid));
            words = 0;
          end
        end
        expect_idle = 1'b0;
        if (busy) begin
          exp_x   = req[grant_id] && !full;
          exp_ack = exp_x ? (one << grant_id) : '0;
          check("w_en", 32'(w_en), 32'(exp_x));
          check("ack", 32'(ack), 32'(exp_ack));
          if (exp_x) begin
            if (exp_q[grant_id].size() == 0) begin
              check("unexpected_word", 32'(1), 32'(0));
            end else begin
              e = exp_q[grant_id].pop_front();
              check("w_data", 32'(w_data), 32'(e[7:0]));
              words++;
              if (e[8] || words == MB) begin
                m_last      = int'(grant_id);
                expect_idle = 1'b1;
              end
            end
          end
        end else begin
          check("idle_outputs", 32'({ack, w_en, w_data}), 32'(0));
        end
        prev_busy = busy;
        prev_req  = req;
        prev_gid  = grant_id;
      end
    end
  end

  // Stimulus
  initial begin
    int n;
    int g;
    req  = 4'hF;
    full = 1'b0;
    repeat (3) @(negedge w_clk);
    #2;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_grant_id", 32'(grant_id), 32'(0));
    check("rst_w_en", 32'(w_en), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_w_data", 32'(w_data), 32'(0));

    @(negedge w_clk);
    req    = '0;
    w_rstn = 1'b1;
    mon_en = 1'b1;

    for (int c = 0; c < 3000; c++) drive_cycle(1'b1);
    g = 0;
    while ((pending() != 0 || req != '0) && g < 3000) begin
      drive_cycle(1'b0);
      g++;
    end
    check("drain_timeout", 32'(pending()), 32'(0));
    @(negedge w_clk);
    mon_en = 1'b0;
    check("scoreboard_leftover", 32'(leftover()), 32'(0));

    // Mid-packet asynchronous reset, then requester 1 must win over 2.
    full = 1'b0;
    last = '0;
    req  = 4'b0001;
    req_data[7:0] = 8'h50;
    n = 0;
    g = 0;
    while (n < 2 && g < 20) begin
      #2;
      if (ack[0]) n++;
      @(negedge w_clk);
      req_data[7:0] = 8'h50 + 8'(n);
      g++;
    end
    check("rst_setup_words", 32'(n), 32'(2));
    #2;
    check("pre_rst_busy", 32'(busy), 32'(1));
    check("pre_rst_ack", 32'(ack), 32'(1));
    w_rstn = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_w_en", 32'(w_en), 32'(0));
    check("async_rst_ack", 32'(ack), 32'(0));
    req  = 4'b0110;
    last = 4'b0110;
    req_data[1*DW +: DW] = 8'h11;
    req_data[2*DW +: DW] = 8'h22;
    @(negedge w_clk);
    w_rstn = 1'b1;
    @(negedge w_clk);
    #2;
    check("post_rst_busy", 32'(busy), 32'(1));
    check("post_rst_grant", 32'(grant_id), 32'(1));
    check("post_rst_w_data", 32'(w_data), 32'(8'h11));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter for fifo_asyn. It shares the FIFO write side (w_en, w_data, full) among NUM_REQ requesters in the w_clk domain. Each grant is packet-atomic and bounded by MAX_BURST words, so no requester can monopolise the FIFO. It sits between the write-domain producers and the fifo_asyn write port.

Parameters:
DATA_WIDTH, 8, word width; matches fifo_asyn DATA_WIDTH.
NUM_REQ, 4, number of requesters (2..16).
MAX_BURST, 8, maximum words per grant (default equals FIFO depth 2**3).
GW, $clog2(NUM_REQ), grant_id width (derived, localparam).

Ports:
w_clk  in  1  write-domain clock, rising edge.
w_rstn  in  1  asynchronous active-low reset.
req  in  NUM_REQ  per-requester "word valid".
last  in  NUM_REQ  per-requester end-of-packet marker, qualified by req.
req_data  in  NUM_REQ*DATA_WIDTH  requester i word in slice [i*DATA_WIDTH +: DATA_WIDTH].
ack  out  NUM_REQ  one-hot; word accepted this cycle.
full  in  1  fifo_asyn full flag.
w_en  out  1  FIFO write enable.
w_data  out  DATA_WIDTH  FIFO write data.
grant_id  out  GW  index of the current owner (valid while busy).
busy  out  1  a grant is held (state BUSY).

Behaviour:
- Only one clock and one reset are used. Reset is asynchronous and active-low: w_rstn low immediately forces state IDLE, busy=0, grant_id=0, burst_cnt=0, and last_grant=NUM_REQ-1 so requester 0 has top priority after reset. ack, w_en and w_data are 0 while in reset.
- FSM states:
  - IDLE: if any req bit is set, register grant_id = the first set req index searching from last_grant+1 upward, wrapping modulo NUM_REQ. Clear burst_cnt and go to BUSY. Otherwise stay in IDLE. There is no transfer in IDLE, so arbitration latency is 1 cycle.
  - BUSY: xfer = req[grant_id] & ~full. Outputs are combinational from registered state:
    - ack[grant_id] = xfer; all other ack bits are 0.
    - w_en = xfer.
    - w_data = req_data slice of grant_id when xfer; 0 otherwise.
  - On xfer: burst_cnt increments. If last[grant_id] is set or burst_cnt == MAX_BURST-1, set last_grant = grant_id and go to IDLE.
- Grant hold rules:
  - req[grant_id] low in BUSY: grant is held (packet-atomic) and nothing is written.
  - full high: xfer is blocked, ack=0, w_en=0, grant is held, burst_cnt is unchanged.
- Requesters must hold req, last and req_data stable until ack. Words are accepted only on cycles where ack is high.
- A 1-cycle bubble (IDLE) always separates consecutive grants, including a re-grant to the same requester.
- Burst cap: a packet longer than MAX_BURST is split. The owner re-competes and is granted again only after the other pending requesters have been served in rotation.
- Simultaneous last and burst cap on the same xfer: treat as a single grant end.
- req changes on non-owners during BUSY have no effect until the next IDLE.
- burst_cnt width is $clog2(MAX_BURST)+1 and it never exceeds MAX_BURST-1.
- Reset asserted mid-packet abandons the packet. After release the arbiter is in IDLE with requester 0 at top priority.

Test Plan:
- Reset, then req=4'b0001 with data 8'hA0..A2 and last on the 3rd word: busy rises 1 cycle after req, grant_id=0. Then 3 consecutive w_en pulses with w_data A0,A1,A2 and ack[0] on each; IDLE on the next cycle.
- req=4'b1111 continuous, every word has last=1, each requester i sends 8'h10*i: grant order 0,1,2,3,0,…, with one IDLE cycle between grants. w_data sequence 00,10,20,30,00.
- Requester 2 streams 12 words without last while req[1] is high, MAX_BURST=8: 8 words from 2, then 1's packet, then the remaining 4 from 2. Never more than 8 consecutive w_en with grant_id=2.
- full forced high for 3 cycles mid-packet: ack=0, w_en=0 during those cycles, grant_id unchanged. No word is lost or duplicated; the next w_data equals the stalled word.
- Integration with fifo_asyn (depth 8, w_clk 350 MHz, r_clk 300 MHz, r_en low): writing 10 words stops at 8 with full=1. Enabling r_en reads the 8 words in arbitrated order, then the remaining 2 words are written.
- w_rstn pulsed low mid-packet (after 2 of 5 words): ack, w_en and busy drop immediately. After release with req=4'b0110, grant_id=1 is granted first.
